// File: rtl/bip_datapath_ext.sv
// bip_datapath_ext: BIP accumulator datapath with logic/shift ALU and shift-add multiplier.
// Latency: single-cycle ops write ACC/flags at the next edge; MUL writes after W busy cycles.
// Backpressure: o_busy high while multiplying; all inputs (including i_wr_acc) are ignored then.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   i_imm             - immediate field, extended to W per SIGN_EXT_IMM
//   i_mem_data        - operand from data memory
//   i_sel_a           - ACC source: 00 mem, 01 imm, 10 ALU, 11 hold
//   i_sel_b           - ALU B operand: 0 mem, 1 imm
//   i_op              - ALU op: ADD SUB AND OR XOR SHL SRA MUL
//   i_wr_acc          - ACC write strobe
//   o_acc             - ACC register
//   o_flags           - {Z, N, C, V}, registered
//   o_busy            - multiplier running
//   o_done            - one-cycle pulse after the multiply result is written
module bip_datapath_ext #(
  parameter int W            = 16,
  parameter int IMM_W        = 11,
  parameter bit SIGN_EXT_IMM = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IMM_W-1:0] i_imm,
  input  logic [W-1:0]     i_mem_data,
  input  logic [1:0]       i_sel_a,
  input  logic             i_sel_b,
  input  logic [2:0]       i_op,
  input  logic             i_wr_acc,
  output logic [W-1:0]     o_acc,
  output logic [3:0]       o_flags,
  output logic             o_busy,
  output logic             o_done
);

  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] SEL_MEM  = 2'b00;
  localparam logic [1:0] SEL_IMM  = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_MUL_RUN
  } state_t;

  // Architectural state
  state_t          r_state;
  logic [W-1:0]    r_acc;
  logic [3:0]      r_flags;
  logic            r_busy;
  logic            r_done;

  // Multiplier state
  logic [W-1:0]    r_mcand;
  logic [W-1:0]    r_mplier;
  logic [2*W-1:0]  r_prod;
  logic [CW-1:0]   r_cnt;

  // Operand path
  logic [W-1:0]    w_imm_ext;
  logic [W-1:0]    w_b;
  logic [SW-1:0]   w_sh;

  // ALU intermediates
  logic [W:0]      w_add;
  logic [W:0]      w_sub;
  logic [W:0]      w_shl;
  logic [W:0]      w_sra;
  logic [W-1:0]    w_alu_res;
  logic            w_alu_c;
  logic            w_alu_v;

  // Selected write-back value and its flags
  logic [W-1:0]    w_new_acc;
  logic            w_new_c;
  logic            w_new_v;
  logic [3:0]      w_new_flags;
  logic            w_start_mul;

  // Multiplier step
  logic [W-1:0]    w_mul_addend;
  logic [W:0]      w_mul_upper;
  logic [2*W-1:0]  w_prod_next;
  logic [W-1:0]    w_mul_lo;
  logic [3:0]      w_mul_flags;

  // ------------------------------------------------------------------
  // Immediate extension and B operand
  // ------------------------------------------------------------------
  always_comb begin
    // Fill first, then overlay the field; also works when IMM_W == W.
    w_imm_ext = (SIGN_EXT_IMM && i_imm[IMM_W-1]) ? {W{1'b1}} : {W{1'b0}};
    w_imm_ext[IMM_W-1:0] = i_imm;
  end

  assign w_b  = i_sel_b ? w_imm_ext : i_mem_data;
  assign w_sh = w_b[SW-1:0];

  // ------------------------------------------------------------------
  // ALU
  // ------------------------------------------------------------------
  // One extra bit on add/sub captures carry/borrow directly.
  assign w_add = {1'b0, r_acc} + {1'b0, w_b};
  assign w_sub = {1'b0, r_acc} - {1'b0, w_b};

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // spare bit; a zero shift leaves the spare bit 0, which is the required C.
  assign w_shl = {1'b0, r_acc} << w_sh;
  assign w_sra = $signed({r_acc, 1'b0}) >>> w_sh;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_alu_res = w_add[W-1:0];
        w_alu_c   = w_add[W];
        w_alu_v   = (r_acc[W-1] == w_b[W-1]) && (w_add[W-1] != r_acc[W-1]);
      end
      OP_SUB: begin
        w_alu_res = w_sub[W-1:0];
        w_alu_c   = w_sub[W];
        w_alu_v   = (r_acc[W-1] != w_b[W-1]) && (w_sub[W-1] != r_acc[W-1]);
      end
      OP_AND: w_alu_res = r_acc & w_b;
      OP_OR:  w_alu_res = r_acc | w_b;
      OP_XOR: w_alu_res = r_acc ^ w_b;
      OP_SHL: begin
        w_alu_res = w_shl[W-1:0];
        w_alu_c   = w_shl[W];
      end
      OP_SRA: begin
        w_alu_res = w_sra[W:1];
        w_alu_c   = w_sra[0];
      end
      default: begin
        // MUL goes through the multi-cycle path, never this mux.
        w_alu_res = r_acc;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // ACC source select and flags for single-cycle writes
  // ------------------------------------------------------------------
  always_comb begin
    w_new_acc = r_acc;
    w_new_c   = 1'b0;
    w_new_v   = 1'b0;
    case (i_sel_a)
      SEL_MEM: w_new_acc = i_mem_data;
      SEL_IMM: w_new_acc = w_imm_ext;
      SEL_ALU: begin
        w_new_acc = w_alu_res;
        w_new_c   = w_alu_c;
        w_new_v   = w_alu_v;
      end
      default: w_new_acc = r_acc;
    endcase
  end

  assign w_new_flags = {(w_new_acc == '0), w_new_acc[W-1], w_new_c, w_new_v};
  assign w_start_mul = i_wr_acc && (i_sel_a == SEL_ALU) && (i_op == OP_MUL);

  // ------------------------------------------------------------------
  // Shift-add multiplier step
  // ------------------------------------------------------------------
  // Add the multiplicand into the upper half (keeping its carry), then shift
  // the whole (2W+1)-bit value right by one; the dropped LSB is finished.
  assign w_mul_addend = r_mplier[0] ? r_mcand : '0;
  assign w_mul_upper  = {1'b0, r_prod[2*W-1:W]} + {1'b0, w_mul_addend};
  assign w_prod_next  = {w_mul_upper, r_prod[W-1:1]};
  assign w_mul_lo     = w_prod_next[W-1:0];
  assign w_mul_flags  = {(w_mul_lo == '0), w_mul_lo[W-1],
                         (w_prod_next[2*W-1:W] != '0), 1'b0};

  // ------------------------------------------------------------------
  // Control FSM and all architectural registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_mul) begin
            r_mcand  <= r_acc;
            r_mplier <= w_b;
            r_prod   <= '0;
            r_cnt    <= CW'(W);
            r_busy   <= 1'b1;
            r_state  <= S_MUL_RUN;
          end else if (i_wr_acc && (i_sel_a != SEL_HOLD)) begin
            r_acc   <= w_new_acc;
            r_flags <= w_new_flags;
          end
        end
        S_MUL_RUN: begin
          r_prod   <= w_prod_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          // The last step's result goes straight to ACC on the same edge
          // that busy drops, so it is taken from the next-product value.
          if (r_cnt == CW'(1)) begin
            r_acc   <= w_mul_lo;
            r_flags <= w_mul_flags;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_acc   = r_acc;
  assign o_flags = r_flags;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_bip_datapath_ext.sv
// tb_bip_datapath_ext: self-checking bench for bip_datapath_ext (W=16, IMM_W=11).
// Expected ACC/flags are pushed to a queue when an op is driven and popped
// when the DUT writes the result; a second instance covers sign-extension.
module tb_bip_datapath_ext;

  logic        clk;
  logic        reset;
  logic [10:0] i_imm;
  logic [15:0] i_mem_data;
  logic [1:0]  i_sel_a;
  logic        i_sel_b;
  logic [2:0]  i_op;
  logic        i_wr_acc;
  logic [15:0] o_acc;
  logic [3:0]  o_flags;
  logic        o_busy;
  logic        o_done;
  logic [15:0] sx_acc;
  logic [3:0]  sx_flags;
  logic        sx_busy;
  logic        sx_done;

  typedef struct packed {
    logic [15:0] acc;
    logic [3:0]  flags;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_acc;
  logic [3:0]  m_flags;
  int          total;
  int          bad;

  bip_datapath_ext #(.W(16), .IMM_W(11), .SIGN_EXT_IMM(1'b0)) u_dut (
    .clk(clk), .reset(reset), .i_imm(i_imm), .i_mem_data(i_mem_data),
    .i_sel_a(i_sel_a), .i_sel_b(i_sel_b), .i_op(i_op), .i_wr_acc(i_wr_acc),
    .o_acc(o_acc), .o_flags(o_flags), .o_busy(o_busy), .o_done(o_done)
  );

  bip_datapath_ext #(.W(16), .IMM_W(11), .SIGN_EXT_IMM(1'b1)) u_dut_sx (
    .clk(clk), .reset(reset), .i_imm(i_imm), .i_mem_data(i_mem_data),
    .i_sel_a(i_sel_a), .i_sel_b(i_sel_b), .i_op(i_op), .i_wr_acc(i_wr_acc),
    .o_acc(sx_acc), .o_flags(sx_flags), .o_busy(sx_busy), .o_done(sx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Single-cycle op: model result, push, drive, pop and compare after the edge.
  task automatic op1(input string tag, input logic [1:0] sa, input logic sb,
                     input logic [2:0] op, input logic [10:0] imm, input logic [15:0] mem);
    exp_t        e;
    logic [15:0] b;
    logic [15:0] res;
    logic [31:0] t;
    logic [3:0]  sh;
    logic        c;
    logic        v;
    int          ai;
    int          bi;
    int          ri;
    b   = sb ? {5'b0, imm} : mem;
    sh  = b[3:0];
    res = m_acc;
    c   = 1'b0;
    v   = 1'b0;
    ai  = $signed(m_acc);
    bi  = $signed(b);
    if (sa == 2'b00) res = mem;
    else if (sa == 2'b01) res = {5'b0, imm};
    else if (sa == 2'b10) begin
      case (op)
        3'd0: begin
          t = {16'b0, m_acc} + {16'b0, b};
          res = t[15:0]; c = t[16];
          ri = ai + bi; v = (ri > 32767) || (ri < -32768);
        end
        3'd1: begin
          res = m_acc - b; c = (m_acc < b);
          ri = ai - bi; v = (ri > 32767) || (ri < -32768);
        end
        3'd2: res = m_acc & b;
        3'd3: res = m_acc | b;
        3'd4: res = m_acc ^ b;
        3'd5: begin
          t = {16'b0, m_acc} << sh;
          res = t[15:0]; c = t[16];
        end
        default: begin
          res = $signed(m_acc) >>> sh;
          c = (sh == 4'd0) ? 1'b0 : m_acc[sh - 4'd1];
        end
      endcase
    end
    if (sa != 2'b11) begin
      m_acc   = res;
      m_flags = {(res == 16'h0), res[15], c, v};
    end
    e.acc = m_acc;
    e.flags = m_flags;
    q.push_back(e);
    i_sel_a = sa; i_sel_b = sb; i_op = op; i_imm = imm; i_mem_data = mem; i_wr_acc = 1'b1;
    @(posedge clk); #1;
    i_wr_acc = 1'b0;
    e = q.pop_front();
    chk({tag, "_acc"}, {16'h0, o_acc}, {16'h0, e.acc});
    chk({tag, "_flags"}, {28'h0, o_flags}, {28'h0, e.flags});
    chk({tag, "_done_low"}, {31'h0, o_done}, 32'h0);
  endtask

  // MUL: start, watch the busy window (optionally scrambling inputs), then
  // compare the result in the o_done cycle. Returns with the next edge free.
  task automatic mul_op(input string tag, input logic sb, input logic [10:0] imm,
                        input logic [15:0] mem, input bit toggle);
    exp_t        e;
    logic [15:0] b;
    logic [31:0] prod;
    logic [15:0] pre_acc;
    logic [3:0]  pre_flags;
    int          n;
    b         = sb ? {5'b0, imm} : mem;
    prod      = {16'h0, m_acc} * {16'h0, b};
    pre_acc   = m_acc;
    pre_flags = m_flags;
    m_acc     = prod[15:0];
    m_flags   = {(prod[15:0] == 16'h0), prod[15], (prod[31:16] != 16'h0), 1'b0};
    e.acc = m_acc;
    e.flags = m_flags;
    q.push_back(e);
    i_sel_a = 2'b10; i_sel_b = sb; i_op = 3'b111; i_imm = imm; i_mem_data = mem; i_wr_acc = 1'b1;
    @(posedge clk); #1;
    i_wr_acc = 1'b0;
    chk({tag, "_busy_start"}, {31'h0, o_busy}, 32'h1);
    n = 0;
    while (o_busy === 1'b1 && n < 64) begin
      chk({tag, "_acc_hold"}, {16'h0, o_acc}, {16'h0, pre_acc});
      chk({tag, "_flags_hold"}, {28'h0, o_flags}, {28'h0, pre_flags});
      chk({tag, "_done_early"}, {31'h0, o_done}, 32'h0);
      if (toggle) begin
        i_wr_acc   = 1'($urandom);
        i_sel_a    = 2'($urandom);
        i_sel_b    = 1'($urandom);
        i_op       = 3'($urandom);
        i_imm      = 11'($urandom);
        i_mem_data = 16'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    i_wr_acc = 1'b0;
    chk({tag, "_busy_cycles"}, n, 16);
    chk({tag, "_done_pulse"}, {31'h0, o_done}, 32'h1);
    e = q.pop_front();
    chk({tag, "_acc"}, {16'h0, o_acc}, {16'h0, e.acc});
    chk({tag, "_flags"}, {28'h0, o_flags}, {28'h0, e.flags});
  endtask

  initial begin
    bit seen_done;
    total = 0; bad = 0;
    m_acc = 16'h0; m_flags = 4'h0;
    reset = 1'b0;
    i_imm = '0; i_mem_data = '0; i_sel_a = 2'b00; i_sel_b = 1'b0; i_op = 3'b000; i_wr_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", {16'h0, o_acc}, 32'h0);
    chk("rst_flags", {28'h0, o_flags}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_done", {31'h0, o_done}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Loads and immediate extension
    op1("ld_imm", 2'b01, 1'b0, 3'd0, 11'h7FF, 16'h0);
    chk("sx_acc", {16'h0, sx_acc}, 32'h0000_FFFF);
    chk("sx_flags", {28'h0, sx_flags}, 32'h4);

    // Add/sub flags
    op1("ld_7fff", 2'b00, 1'b0, 3'd0, 11'h0, 16'h7FFF);
    op1("add_ovf", 2'b10, 1'b0, 3'd0, 11'h0, 16'h0001);
    op1("ld_0", 2'b01, 1'b0, 3'd0, 11'h0, 16'h0);
    op1("sub_brw", 2'b10, 1'b1, 3'd1, 11'h001, 16'h0);
    op1("ld_1234", 2'b00, 1'b0, 3'd0, 11'h0, 16'h1234);
    op1("sub_zero", 2'b10, 1'b0, 3'd1, 11'h0, 16'h1234);
    op1("ld_ffff", 2'b00, 1'b0, 3'd0, 11'h0, 16'hFFFF);
    op1("add_cry", 2'b10, 1'b1, 3'd0, 11'h001, 16'h0);

    // Logic and shifts
    op1("ld_f0f0", 2'b00, 1'b0, 3'd0, 11'h0, 16'hF0F0);
    op1("xor", 2'b10, 1'b0, 3'd4, 11'h0, 16'hFFFF);
    op1("ld_ff0f", 2'b00, 1'b0, 3'd0, 11'h0, 16'hFF0F);
    op1("and", 2'b10, 1'b1, 3'd2, 11'h0F0, 16'h0);
    op1("or", 2'b10, 1'b0, 3'd3, 11'h0, 16'h1234);
    op1("ld_8001", 2'b00, 1'b0, 3'd0, 11'h0, 16'h8001);
    op1("shl1", 2'b10, 1'b1, 3'd5, 11'h001, 16'h0);
    op1("shl0", 2'b10, 1'b0, 3'd5, 11'h0, 16'h0010);
    op1("ld_8000", 2'b00, 1'b0, 3'd0, 11'h0, 16'h8000);
    op1("sra15", 2'b10, 1'b1, 3'd6, 11'h00F, 16'h0);
    op1("ld_00f3", 2'b00, 1'b0, 3'd0, 11'h0, 16'h00F3);
    op1("sra2", 2'b10, 1'b1, 3'd6, 11'h002, 16'h0);
    op1("hold", 2'b11, 1'b0, 3'd0, 11'h7FF, 16'hFFFF);

    // Multiply, then a back-to-back MUL issued at E0+W+1 with scrambled inputs
    op1("ld_00ff", 2'b00, 1'b0, 3'd0, 11'h0, 16'h00FF);
    mul_op("mul_a", 1'b1, 11'h101, 16'h0, 1'b0);
    mul_op("mul_b2b", 1'b0, 11'h0, 16'hFFFF, 1'b1);
    op1("ld_1000", 2'b00, 1'b0, 3'd0, 11'h0, 16'h1000);
    mul_op("mul_hi", 1'b0, 11'h0, 16'h0010, 1'b1);
    op1("ld_00ff_b", 2'b00, 1'b0, 3'd0, 11'h0, 16'h00FF);
    mul_op("mul_tog", 1'b1, 11'h101, 16'h0, 1'b1);
    op1("after_mul", 2'b10, 1'b0, 3'd0, 11'h0, 16'h0001);

    // Reset in the middle of a multiply
    op1("ld_0123", 2'b00, 1'b0, 3'd0, 11'h0, 16'h0123);
    i_sel_a = 2'b10; i_sel_b = 1'b0; i_op = 3'b111; i_mem_data = 16'h0045; i_wr_acc = 1'b1;
    @(posedge clk); #1;
    i_wr_acc = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("mid_busy", {31'h0, o_busy}, 32'h1);
    reset = 1'b0;
    #2;
    chk("mid_rst_acc", {16'h0, o_acc}, 32'h0);
    chk("mid_rst_flags", {28'h0, o_flags}, 32'h0);
    chk("mid_rst_busy", {31'h0, o_busy}, 32'h0);
    #1;
    reset = 1'b1;
    q.delete();
    m_acc = 16'h0; m_flags = 4'h0;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) seen_done = 1'b1;
    end
    chk("mid_no_done", {31'h0, seen_done}, 32'h0);
    chk("mid_idle_busy", {31'h0, o_busy}, 32'h0);
    op1("add_post_rst", 2'b10, 1'b0, 3'd0, 11'h0, 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
